// File: rtl/pe_out_collector.sv
// Collects per-lane PE results into lane FIFOs and re-serialises them lane 0 first onto one valid/ready stream.
// Optional COLLECT_LANE_TAG_EN adds dout_pe_id, the source lane of each output beat.
module pe_out_collector #(
   parameter int PE_NUM     = 8,
   parameter int DATA_WIDTH = 16,
   parameter int RES_NUM    = 4,
   parameter int FIFO_DEPTH = 8,
   localparam int BW   = 2 * DATA_WIDTH,
   localparam int PE_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PE_NUM-1:0]      pe_out_v,
   input  logic [PE_NUM*BW-1:0]   pe_out,
   input  logic                   dout_ready,
   output logic                   dout_overlay_v,
   output logic [BW-1:0]          dout_overlay,
   output logic                   frame_done,
   output logic                   overflow,
`ifdef COLLECT_LANE_TAG_EN
   output logic [PE_W-1:0]        dout_pe_id,
`endif
   output logic [1:0]             dbg_state
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int BC_W = (RES_NUM > 1) ? $clog2(RES_NUM) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2} state_t;

   state_t            r_state, w_state_nxt;
   logic [PE_W-1:0]   r_cur_pe, w_cur_pe_nxt;
   logic [BC_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
   logic              r_frame_done, w_frame_done_nxt;

   logic [BW-1:0]     r_mem [PE_NUM][FIFO_DEPTH];
   logic [AW:0]       r_wr_ptr [PE_NUM];
   logic [AW:0]       r_rd_ptr [PE_NUM];
   logic [PE_NUM-1:0] w_empty, w_full, w_push, w_pop_lane;
   logic              w_out_free, w_pop;
   logic [BW-1:0]     w_head;

   logic              r_v;
   logic [BW-1:0]     r_data;
   logic              r_overflow;

   // Output handshake: a beat transfers when dout_overlay_v && dout_ready; while
   // dout_ready is low the held beat and its valid stay unchanged.
   assign w_out_free = !r_v || dout_ready;
   assign w_pop      = (r_state == S_DRAIN) && !w_empty[r_cur_pe] && w_out_free;
   assign w_head     = r_mem[r_cur_pe][r_rd_ptr[r_cur_pe][AW-1:0]];

   always_comb begin
      for (int k = 0; k < PE_NUM; k++) begin
         w_empty[k]    = (r_wr_ptr[k] == r_rd_ptr[k]);
         w_full[k]     = (r_wr_ptr[k][AW] != r_rd_ptr[k][AW]) &&
                         (r_wr_ptr[k][AW-1:0] == r_rd_ptr[k][AW-1:0]);
         w_pop_lane[k] = w_pop && (r_cur_pe == PE_W'(k));
         // A full lane still accepts a write when it is popped in the same cycle.
         w_push[k]     = pe_out_v[k] && (!w_full[k] || w_pop_lane[k]);
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < PE_NUM; k++) begin
         if (w_push[k]) r_mem[k][r_wr_ptr[k][AW-1:0]] <= pe_out[k*BW +: BW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < PE_NUM; k++) begin
            r_wr_ptr[k] <= '0;
            r_rd_ptr[k] <= '0;
         end
         r_overflow <= 1'b0;
      end else begin
         for (int k = 0; k < PE_NUM; k++) begin
            if (w_push[k])                r_wr_ptr[k] <= r_wr_ptr[k] + (AW+1)'(1);
            if (w_pop_lane[k])            r_rd_ptr[k] <= r_rd_ptr[k] + (AW+1)'(1);
            if (pe_out_v[k] && !w_push[k]) r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cur_pe     <= '0;
         r_beat_cnt   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cur_pe     <= w_cur_pe_nxt;
         r_beat_cnt   <= w_beat_cnt_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_cur_pe_nxt     = r_cur_pe;
      w_beat_cnt_nxt   = r_beat_cnt;
      w_frame_done_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cur_pe_nxt   = '0;
            w_beat_cnt_nxt = '0;
            // Leaving on the incoming lane-0 write keeps first-beat latency at two cycles.
            if (!w_empty[0] || pe_out_v[0]) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_pop) begin
               if (r_beat_cnt < BC_W'(RES_NUM - 1)) begin
                  w_beat_cnt_nxt = r_beat_cnt + BC_W'(1);
               end else begin
                  w_beat_cnt_nxt = '0;
                  if (r_cur_pe < PE_W'(PE_NUM - 1)) w_cur_pe_nxt = r_cur_pe + PE_W'(1);
                  else                              w_state_nxt  = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (w_out_free) begin
               w_frame_done_nxt = 1'b1;
               w_state_nxt      = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v    <= 1'b0;
         r_data <= '0;
      end else if (w_pop) begin
         r_v    <= 1'b1;
         r_data <= w_head;
      end else if (dout_ready) begin
         r_v    <= 1'b0;
         r_data <= '0;
      end
   end

`ifdef COLLECT_LANE_TAG_EN
   logic [PE_W-1:0] r_pe_id;

   always_ff @(posedge clk) begin
      if (rst)             r_pe_id <= '0;
      else if (w_pop)      r_pe_id <= r_cur_pe;
      else if (dout_ready) r_pe_id <= '0;
   end

   assign dout_pe_id = r_pe_id;
`else
   // Without the lane tag the output register carries data and valid only.
`endif

   assign dout_overlay_v = r_v;
   assign dout_overlay   = r_data;
   assign frame_done     = r_frame_done;
   assign overflow       = r_overflow;
   assign dbg_state      = r_state;

endmodule
